// File: rtl/striper_pkg.sv
// Shared symbol codes, scheduler state encoding and lane slicing helper for
// the parametrised byte striper.
package striper_pkg;

    localparam logic [7:0] STP = 8'hFB;
    localparam logic [7:0] SDP = 8'h5C;
    localparam logic [7:0] END = 8'hFD;
    localparam logic [7:0] EDB = 8'hFE;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] SKP = 8'h1C;
    localparam logic [7:0] IDL = 8'h7C;
    localparam logic [7:0] PAD = 8'hF7;

    typedef enum logic [1:0] {
        ST_DATA,
        ST_COM,
        ST_SKP
    } state_t;

    // Bit offset of a lane inside the flattened lane bus; lane 0 sits in the LSBs.
    function automatic int laneBase(input int lane, input int bits);
        return lane * bits;
    endfunction

endpackage

// File: rtl/skp_scheduler.sv
// Counts emitted data groups and sequences the COM + SKP ordered set,
// holding off input while the ordered set occupies the lanes.
module skp_scheduler
    import striper_pkg::*;
#(
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_LEN      = 3
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_group_emit,
    input  logic i_idx_zero,
    input  logic i_in_pkt,
    output logic o_in_ready,
    output logic o_load_com,
    output logic o_load_skp
);

    localparam int GCNT_W = $clog2(SKP_INTERVAL + 1);
    localparam int SCNT_W = $clog2(SKP_LEN + 1);

    state_t             r_state;
    logic [GCNT_W-1:0]  r_group_cnt;
    logic [SCNT_W-1:0]  r_skp_cnt;
    logic               r_pending;
    logic               w_insert;

    // An ordered set may only start on a group boundary outside a packet.
    assign w_insert   = r_pending && i_idx_zero && !i_in_pkt;
    assign o_in_ready = !i_reset && (r_state == ST_DATA) && !w_insert;
    assign o_load_com = (r_state == ST_DATA) && w_insert;
    assign o_load_skp = (r_state == ST_COM) || (r_state == ST_SKP);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_DATA;
            r_group_cnt <= '0;
            r_skp_cnt   <= '0;
            r_pending   <= 1'b0;
        end else begin
            if (i_group_emit) begin
                if (r_group_cnt == GCNT_W'(SKP_INTERVAL - 1)) begin
                    r_pending   <= 1'b1;
                    r_group_cnt <= '0;
                end else begin
                    r_group_cnt <= r_group_cnt + GCNT_W'(1);
                end
            end

            // r_skp_cnt counts SKP beats already loaded into the output registers.
            case (r_state)
                ST_DATA: begin
                    if (w_insert) begin
                        r_state <= ST_COM;
                    end
                end
                ST_COM: begin
                    r_skp_cnt <= SCNT_W'(1);
                    if (SKP_LEN == 1) begin
                        r_state   <= ST_DATA;
                        r_pending <= 1'b0;
                    end else begin
                        r_state <= ST_SKP;
                    end
                end
                ST_SKP: begin
                    r_skp_cnt <= r_skp_cnt + SCNT_W'(1);
                    if (r_skp_cnt == SCNT_W'(SKP_LEN - 1)) begin
                        r_state   <= ST_DATA;
                        r_pending <= 1'b0;
                    end
                end
                default: r_state <= ST_DATA;
            endcase
        end
    end

endmodule

// File: rtl/byte_striper_param.sv
// Round-robin striper: gathers symbols into a LANES-wide group, pads short
// packet tails and interleaves scheduled SKP ordered sets.
module byte_striper_param
    import striper_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int BITS         = 8,
    parameter int SKP_INTERVAL = 16,
    parameter int SKP_LEN      = 3
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [BITS-1:0]       i_d,
    input  logic                  i_dk,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [LANES*BITS-1:0] o_lane_d,
    output logic [LANES-1:0]      o_lane_dk,
    output logic                  o_out_valid,
    output logic                  o_out_os
);

    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [BITS-1:0]       r_buf_d [LANES];
    logic [LANES-1:0]      r_buf_dk;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_in_pkt;

    logic                  w_accept;
    logic                  w_is_start;
    logic                  w_is_end;
    logic                  w_emit;
    logic                  w_load_com;
    logic                  w_load_skp;
    logic [LANES*BITS-1:0] w_grp_d;
    logic [LANES-1:0]      w_grp_dk;

    assign w_accept   = i_in_valid && o_in_ready;
    assign w_is_start = i_dk && ((i_d == BITS'(STP)) || (i_d == BITS'(SDP)));
    assign w_is_end   = i_dk && ((i_d == BITS'(END)) || (i_d == BITS'(EDB)));
    assign w_emit     = w_accept && ((r_idx == IDX_W'(LANES - 1)) || w_is_end);

    skp_scheduler #(
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_LEN      (SKP_LEN)
    ) u_sched (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_group_emit (w_emit),
        .i_idx_zero   (r_idx == '0),
        .i_in_pkt     (r_in_pkt),
        .o_in_ready   (o_in_ready),
        .o_load_com   (w_load_com),
        .o_load_skp   (w_load_skp)
    );

    // The closing symbol bypasses the buffer so the group appears one cycle after it.
    always_comb begin
        w_grp_d  = '0;
        w_grp_dk = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(r_idx)) begin
                w_grp_d[laneBase(i, BITS) +: BITS] = r_buf_d[i];
                w_grp_dk[i]                        = r_buf_dk[i];
            end else if (i == int'(r_idx)) begin
                w_grp_d[laneBase(i, BITS) +: BITS] = i_d;
                w_grp_dk[i]                        = i_dk;
            end else begin
                w_grp_d[laneBase(i, BITS) +: BITS] = BITS'(PAD);
                w_grp_dk[i]                        = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset && w_accept && !w_emit) begin
            r_buf_d[r_idx]  <= i_d;
            r_buf_dk[r_idx] <= i_dk;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_idx    <= '0;
            r_in_pkt <= 1'b0;
        end else if (w_accept) begin
            r_idx <= w_emit ? '0 : r_idx + IDX_W'(1);
            if (w_is_start) begin
                r_in_pkt <= 1'b1;
            end else if (w_is_end) begin
                r_in_pkt <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_lane_d    <= {LANES{BITS'(IDL)}};
            o_lane_dk   <= '1;
            o_out_valid <= 1'b0;
            o_out_os    <= 1'b0;
        end else if (w_load_com) begin
            o_lane_d    <= {LANES{BITS'(COM)}};
            o_lane_dk   <= '1;
            o_out_valid <= 1'b1;
            o_out_os    <= 1'b1;
        end else if (w_load_skp) begin
            o_lane_d    <= {LANES{BITS'(SKP)}};
            o_lane_dk   <= '1;
            o_out_valid <= 1'b1;
            o_out_os    <= 1'b1;
        end else if (w_emit) begin
            o_lane_d    <= w_grp_d;
            o_lane_dk   <= w_grp_dk;
            o_out_valid <= 1'b1;
            o_out_os    <= 1'b0;
        end else begin
            o_lane_d    <= {LANES{BITS'(IDL)}};
            o_lane_dk   <= '1;
            o_out_valid <= 1'b0;
            o_out_os    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_byte_striper_param.sv
// Directed bench for byte_striper_param with 4 lanes and an ordered set
// after every second data group.
module tb_byte_striper_param;

    localparam int LANES        = 4;
    localparam int BITS         = 8;
    localparam int SKP_INTERVAL = 2;
    localparam int SKP_LEN      = 3;

    localparam logic [31:0] IDLE_D = 32'h7C7C7C7C;
    localparam logic [31:0] COM_D  = 32'hBCBCBCBC;
    localparam logic [31:0] SKP_D  = 32'h1C1C1C1C;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [BITS-1:0]       dd;
    logic                  dk;
    logic                  inValid;
    logic                  inReady;
    logic [LANES*BITS-1:0] laneD;
    logic [LANES-1:0]      laneDk;
    logic                  outValid;
    logic                  outOs;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic        rst;
        logic        v;
        logic        k;
        logic [7:0]  d;
        logic        expReady;
        logic        expValid;
        logic        expOs;
        logic [31:0] expD;
        logic [3:0]  expDk;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    byte_striper_param #(
        .LANES        (LANES),
        .BITS         (BITS),
        .SKP_INTERVAL (SKP_INTERVAL),
        .SKP_LEN      (SKP_LEN)
    ) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_d         (dd),
        .i_dk        (dk),
        .i_in_valid  (inValid),
        .o_in_ready  (inReady),
        .o_lane_d    (laneD),
        .o_lane_dk   (laneDk),
        .o_out_valid (outValid),
        .o_out_os    (outOs)
    );

    task automatic addVec(input logic rst, input logic v, input logic k, input logic [7:0] d,
                          input logic eR, input logic eV, input logic eO,
                          input logic [31:0] eD, input logic [3:0] eK);
        vec_t t;
        t.rst = rst; t.v = v; t.k = k; t.d = d;
        t.expReady = eR; t.expValid = eV; t.expOs = eO; t.expD = eD; t.expDk = eK;
        vecs.push_back(t);
    endtask

    task automatic addReset();
        addVec(1, 0, 0, 8'h00, 0, 0, 0, IDLE_D, 4'hF);
        addVec(1, 0, 0, 8'h00, 0, 0, 0, IDLE_D, 4'hF);
    endtask

    task automatic addSym(input logic k, input logic [7:0] d);
        addVec(0, 1, k, d, 1, 0, 0, IDLE_D, 4'hF);
    endtask

    task automatic addBeat(input logic k, input logic [7:0] d, input logic [31:0] eD, input logic [3:0] eK);
        addVec(0, 1, k, d, 1, 1, 0, eD, eK);
    endtask

    task automatic addOrderedSet(input logic v, input logic k, input logic [7:0] d);
        addVec(0, v, k, d, 0, 1, 1, COM_D, 4'hF);
        for (int i = 0; i < SKP_LEN; i++) begin
            addVec(0, v, k, d, 0, 1, 1, SKP_D, 4'hF);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v, input logic k, input logic [7:0] d,
                                 output logic readySeen);
        @(negedge clk);
        reset   = rst;
        inValid = v;
        dk      = k;
        dd      = d;
        #1;
        readySeen = inReady;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic readySeen, input logic eR,
                               input logic eV, input logic eO, input logic [31:0] eD, input logic [3:0] eK);
        checks++;
        if (readySeen === eR && outValid === eV && outOs === eO && laneD === eD && laneDk === eK) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got ready=%b valid=%b os=%b d=%h dk=%b, want ready=%b valid=%b os=%b d=%h dk=%b",
                     name, readySeen, outValid, outOs, laneD, laneDk, eR, eV, eO, eD, eK);
        end
    endtask

    task automatic runStep(input string name, input logic rst, input logic v, input logic k, input logic [7:0] d,
                           input logic eR, input logic eV, input logic eO, input logic [31:0] eD, input logic [3:0] eK);
        logic rs;
        applyStimulus(rst, v, k, d, rs);
        checkOutput(name, rs, eR, eV, eO, eD, eK);
    endtask

    task automatic stepIdle(input string name, input logic rst, input logic v, input logic k, input logic [7:0] d,
                            input logic eR);
        runStep(name, rst, v, k, d, eR, 0, 0, IDLE_D, 4'hF);
    endtask

    initial begin
        reset   = 1'b1;
        inValid = 1'b0;
        dk      = 1'b0;
        dd      = '0;

        // Basic packet, then two packets that trigger an ordered set.
        addReset();
        addSym(1, 8'hFB); addSym(0, 8'h33); addSym(0, 8'hFF);
        addBeat(1, 8'hFD, 32'hFDFF33FB, 4'b1001);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, IDLE_D, 4'hF);

        addReset();
        addSym(1, 8'h5C); addSym(0, 8'h55); addSym(0, 8'h41);
        addBeat(1, 8'hFE, 32'hFE41555C, 4'b1001);
        addSym(1, 8'hFB); addSym(0, 8'h01);
        addBeat(1, 8'hFD, 32'hF7FD01FB, 4'b1101);
        addOrderedSet(0, 0, 8'h00);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, IDLE_D, 4'hF);

        // Third packet is held on the input while the ordered set runs.
        addReset();
        addSym(1, 8'hFB); addSym(0, 8'h11); addSym(0, 8'h22);
        addBeat(1, 8'hFD, 32'hFD2211FB, 4'b1001);
        addSym(1, 8'hFB); addSym(0, 8'h33); addSym(0, 8'h44);
        addBeat(1, 8'hFD, 32'hFD4433FB, 4'b1001);
        addOrderedSet(1, 1, 8'hFB);
        addSym(1, 8'hFB); addSym(0, 8'h55); addSym(0, 8'h66);
        addBeat(1, 8'hFD, 32'hFD6655FB, 4'b1001);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, IDLE_D, 4'hF);

        // IN_VALID gaps mid-group.
        addReset();
        addSym(0, 8'hA1);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, IDLE_D, 4'hF);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, IDLE_D, 4'hF);
        addSym(0, 8'hA2); addSym(0, 8'hA3);
        addBeat(0, 8'hA4, 32'hA4A3A2A1, 4'b0000);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, IDLE_D, 4'hF);

        for (int i = 0; i < vecs.size(); i++) begin
            runStep($sformatf("vec%0d", i), vecs[i].rst, vecs[i].v, vecs[i].k, vecs[i].d,
                    vecs[i].expReady, vecs[i].expValid, vecs[i].expOs, vecs[i].expD, vecs[i].expDk);
        end

        // Pending ordered set deferred until the packet ends.
        stepIdle("pk_rst0", 1, 0, 0, 8'h00, 0);
        stepIdle("pk_rst1", 1, 0, 0, 8'h00, 0);
        stepIdle("pk_stp", 0, 1, 1, 8'hFB, 1);
        stepIdle("pk_d1", 0, 1, 0, 8'h01, 1);
        stepIdle("pk_d2", 0, 1, 0, 8'h02, 1);
        runStep("pk_beat1", 0, 1, 0, 8'h03, 1, 1, 0, 32'h030201FB, 4'b0001);
        stepIdle("pk_d4", 0, 1, 0, 8'h04, 1);
        stepIdle("pk_d5", 0, 1, 0, 8'h05, 1);
        stepIdle("pk_d6", 0, 1, 0, 8'h06, 1);
        runStep("pk_beat2", 0, 1, 0, 8'h07, 1, 1, 0, 32'h07060504, 4'b0000);
        stepIdle("pk_inpkt_ready", 0, 1, 0, 8'h08, 1);
        runStep("pk_end_beat", 0, 1, 1, 8'hFD, 1, 1, 0, 32'hF7F7FD08, 4'b1110);
        runStep("pk_com", 0, 0, 0, 8'h00, 0, 1, 1, COM_D, 4'hF);
        for (int i = 0; i < SKP_LEN; i++) begin
            runStep($sformatf("pk_skp%0d", i), 0, 0, 0, 8'h00, 0, 1, 1, SKP_D, 4'hF);
        end
        stepIdle("pk_after", 0, 0, 0, 8'h00, 1);

        // Reset mid-group and again in the middle of the SKP run.
        stepIdle("rs_rst0", 1, 0, 0, 8'h00, 0);
        stepIdle("rs_rst1", 1, 0, 0, 8'h00, 0);
        stepIdle("rs_stp", 0, 1, 1, 8'hFB, 1);
        stepIdle("rs_aa", 0, 1, 0, 8'hAA, 1);
        stepIdle("rs_midgrp", 1, 0, 0, 8'h00, 0);
        stepIdle("rs_stp2", 0, 1, 1, 8'hFB, 1);
        stepIdle("rs_b1", 0, 1, 0, 8'hB1, 1);
        stepIdle("rs_b2", 0, 1, 0, 8'hB2, 1);
        runStep("rs_beat1", 0, 1, 1, 8'hFD, 1, 1, 0, 32'hFDB2B1FB, 4'b1001);
        stepIdle("rs_stp3", 0, 1, 1, 8'hFB, 1);
        stepIdle("rs_c1", 0, 1, 0, 8'hC1, 1);
        stepIdle("rs_c2", 0, 1, 0, 8'hC2, 1);
        runStep("rs_beat2", 0, 1, 1, 8'hFD, 1, 1, 0, 32'hFDC2C1FB, 4'b1001);
        runStep("rs_com", 0, 0, 0, 8'h00, 0, 1, 1, COM_D, 4'hF);
        runStep("rs_skp0", 0, 0, 0, 8'h00, 0, 1, 1, SKP_D, 4'hF);
        stepIdle("rs_in_skp", 1, 0, 0, 8'h00, 0);
        stepIdle("rs_stp4", 0, 1, 1, 8'hFB, 1);
        stepIdle("rs_d1", 0, 1, 0, 8'hD1, 1);
        stepIdle("rs_d2", 0, 1, 0, 8'hD2, 1);
        runStep("rs_beat3", 0, 1, 1, 8'hFD, 1, 1, 0, 32'hFDD2D1FB, 4'b1001);
        stepIdle("rs_no_os", 0, 0, 0, 8'h00, 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
